// File: rtl/idex_forward_reg.sv
// ID/EX pipeline register with operand forwarding.
// Captures the decoded instruction for the EX-stage ALU. RAW hazards are
// resolved at capture time: an operand is taken from the ALU result of the
// instruction now in EX, or from write-back, or from the register file.
// flush inserts a bubble and stall holds every register.
module idex_forward_reg #(
    parameter int         DW        = 8,
    parameter int         AW        = 3,
    parameter logic [3:0] BUBBLE_OP = 4'hF,
    parameter bit         ZERO_REG  = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [3:0]    id_op,
    input  logic [AW-1:0] id_rs1,
    input  logic [AW-1:0] id_rs2,
    input  logic [AW-1:0] id_rd,
    input  logic          id_we,
    input  logic [DW-1:0] id_rd1,
    input  logic [DW-1:0] id_rd2,
    input  logic          id_use_imm,
    input  logic [DW-1:0] id_imm,
    input  logic [DW-1:0] ex_alu_out,
    input  logic          wb_we,
    input  logic [AW-1:0] wb_rd,
    input  logic [DW-1:0] wb_data,
    input  logic          stall,
    input  logic          flush,
    output logic [DW-1:0] alu_in1,
    output logic [DW-1:0] alu_in2,
    output logic [3:0]    alu_op,
    output logic [AW-1:0] ex_rd,
    output logic          ex_we,
    output logic          ex_valid
);

    // Operand select with fixed priority: EX result, then write-back, then
    // register file. Register 0 (when ZERO_REG) always uses register-file data.
    function automatic logic [DW-1:0] fwd(
        input logic [AW-1:0] rs,
        input logic [DW-1:0] rfdata,
        input logic          ex_en,
        input logic [AW-1:0] ex_dst,
        input logic [DW-1:0] ex_res,
        input logic          wb_en,
        input logic [AW-1:0] wb_dst,
        input logic [DW-1:0] wb_res
    );
        logic [DW-1:0] res;
        if (ZERO_REG && (rs == {AW{1'b0}})) begin
            res = rfdata;
        end else if (ex_en && (ex_dst == rs)) begin
            res = ex_res;
        end else if (wb_en && (wb_dst == rs)) begin
            res = wb_data_sel(wb_res);
        end else begin
            res = rfdata;
        end
        return res;
    endfunction

    // Identity helper kept separate so the write-back path reads clearly.
    function automatic logic [DW-1:0] wb_data_sel(input logic [DW-1:0] d);
        return d;
    endfunction

    logic [DW-1:0] nxt_in1_s;
    logic [DW-1:0] nxt_in2_s;
    logic [3:0]    nxt_op_s;
    logic [AW-1:0] nxt_rd_s;
    logic          nxt_we_s;
    logic          nxt_valid_s;
    logic          ex_fwd_en_s;

    // EX result is only a forwarding source when EX holds a writing instruction.
    always_comb begin
        ex_fwd_en_s = ex_valid & ex_we;
    end

    // Next-state selection: flush > stall > load (bubble when decode is empty).
    always_comb begin
        nxt_in1_s   = alu_in1;
        nxt_in2_s   = alu_in2;
        nxt_op_s    = alu_op;
        nxt_rd_s    = ex_rd;
        nxt_we_s    = ex_we;
        nxt_valid_s = ex_valid;
        if (flush || (!stall && !id_valid)) begin
            nxt_in1_s   = {DW{1'b0}};
            nxt_in2_s   = {DW{1'b0}};
            nxt_op_s    = BUBBLE_OP;
            nxt_rd_s    = {AW{1'b0}};
            nxt_we_s    = 1'b0;
            nxt_valid_s = 1'b0;
        end else if (stall) begin
            nxt_in1_s   = alu_in1;
            nxt_in2_s   = alu_in2;
            nxt_op_s    = alu_op;
            nxt_rd_s    = ex_rd;
            nxt_we_s    = ex_we;
            nxt_valid_s = ex_valid;
        end else begin
            nxt_in1_s   = fwd(id_rs1, id_rd1, ex_fwd_en_s, ex_rd, ex_alu_out,
                              wb_we, wb_rd, wb_data);
            if (id_use_imm) begin
                nxt_in2_s = id_imm;
            end else begin
                nxt_in2_s = fwd(id_rs2, id_rd2, ex_fwd_en_s, ex_rd, ex_alu_out,
                                wb_we, wb_rd, wb_data);
            end
            nxt_op_s    = id_op;
            nxt_rd_s    = id_rd;
            nxt_we_s    = id_we;
            nxt_valid_s = 1'b1;
        end
    end

    // Pipeline register; synchronous reset loads the bubble state.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_in1  <= {DW{1'b0}};
            alu_in2  <= {DW{1'b0}};
            alu_op   <= BUBBLE_OP;
            ex_rd    <= {AW{1'b0}};
            ex_we    <= 1'b0;
            ex_valid <= 1'b0;
        end else begin
            alu_in1  <= nxt_in1_s;
            alu_in2  <= nxt_in2_s;
            alu_op   <= nxt_op_s;
            ex_rd    <= nxt_rd_s;
            ex_we    <= nxt_we_s;
            ex_valid <= nxt_valid_s;
        end
    end

endmodule

// File: tb/tb_idex_forward_reg.sv
// Directed testbench for idex_forward_reg.
module tb_idex_forward_reg;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [3:0] id_op;
    logic [2:0] id_rs1;
    logic [2:0] id_rs2;
    logic [2:0] id_rd;
    logic       id_we;
    logic [7:0] id_rd1;
    logic [7:0] id_rd2;
    logic       id_use_imm;
    logic [7:0] id_imm;
    logic [7:0] ex_alu_out;
    logic       wb_we;
    logic [2:0] wb_rd;
    logic [7:0] wb_data;
    logic       stall;
    logic       flush;
    logic [7:0] alu_in1;
    logic [7:0] alu_in2;
    logic [3:0] alu_op;
    logic [2:0] ex_rd;
    logic       ex_we;
    logic       ex_valid;

    int n_assert = 0;
    int n_fail   = 0;

    idex_forward_reg dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_op      (id_op),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_rd      (id_rd),
        .id_we      (id_we),
        .id_rd1     (id_rd1),
        .id_rd2     (id_rd2),
        .id_use_imm (id_use_imm),
        .id_imm     (id_imm),
        .ex_alu_out (ex_alu_out),
        .wb_we      (wb_we),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .stall      (stall),
        .flush      (flush),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_op     (alu_op),
        .ex_rd      (ex_rd),
        .ex_we      (ex_we),
        .ex_valid   (ex_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic instr(input logic [3:0] op, input logic [2:0] rs1, input logic [2:0] rs2,
                         input logic [2:0] rd, input logic we, input logic [7:0] rd1,
                         input logic [7:0] rd2, input logic use_imm, input logic [7:0] imm);
        id_valid   = 1'b1;
        id_op      = op;
        id_rs1     = rs1;
        id_rs2     = rs2;
        id_rd      = rd;
        id_we      = we;
        id_rd1     = rd1;
        id_rd2     = rd2;
        id_use_imm = use_imm;
        id_imm     = imm;
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, "_valid"}, {15'd0, ex_valid}, 16'd0);
        chk({tag, "_we"},    {15'd0, ex_we},    16'd0);
        chk({tag, "_rd"},    {13'd0, ex_rd},    16'd0);
        chk({tag, "_op"},    {12'd0, alu_op},   16'h000F);
        chk({tag, "_in1"},   {8'd0, alu_in1},   16'd0);
        chk({tag, "_in2"},   {8'd0, alu_in2},   16'd0);
    endtask

    initial begin
        // Reset with random inputs
        rst        = 1'b1;
        id_valid   = 1'($urandom);
        id_op      = 4'($urandom);
        id_rs1     = 3'($urandom);
        id_rs2     = 3'($urandom);
        id_rd      = 3'($urandom);
        id_we      = 1'($urandom);
        id_rd1     = 8'($urandom);
        id_rd2     = 8'($urandom);
        id_use_imm = 1'($urandom);
        id_imm     = 8'($urandom);
        ex_alu_out = 8'($urandom);
        wb_we      = 1'($urandom);
        wb_rd      = 3'($urandom);
        wb_data    = 8'($urandom);
        stall      = 1'($urandom);
        flush      = 1'($urandom);
        tick();
        tick();
        chk_bubble("reset");

        rst      = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;
        id_valid = 1'b0;
        tick();
        chk_bubble("idle");

        // Plain load, no hazards
        wb_we = 1'b0;
        instr(4'h0, 3'd1, 3'd2, 3'd3, 1'b1, 8'h12, 8'h34, 1'b0, 8'h00);
        tick();
        chk("load_in1",   {8'd0, alu_in1},   16'h0012);
        chk("load_in2",   {8'd0, alu_in2},   16'h0034);
        chk("load_op",    {12'd0, alu_op},   16'h0000);
        chk("load_valid", {15'd0, ex_valid}, 16'd1);
        chk("load_rd",    {13'd0, ex_rd},    16'd3);
        chk("load_we",    {15'd0, ex_we},    16'd1);

        // EX forward beats WB forward on the same register
        ex_alu_out = 8'hA5;
        wb_we      = 1'b1;
        wb_rd      = 3'd3;
        wb_data    = 8'h5A;
        instr(4'h2, 3'd3, 3'd4, 3'd3, 1'b0, 8'h00, 8'h66, 1'b0, 8'h00);
        tick();
        chk("exfwd_in1", {8'd0, alu_in1}, 16'h00A5);
        chk("exfwd_in2", {8'd0, alu_in2}, 16'h0066);
        chk("exfwd_op",  {12'd0, alu_op}, 16'h0002);
        chk("exfwd_we",  {15'd0, ex_we},  16'd0);

        // EX instruction does not write: WB supplies both operands
        instr(4'h1, 3'd3, 3'd3, 3'd6, 1'b1, 8'h00, 8'h11, 1'b0, 8'h00);
        tick();
        chk("wbfwd_in1", {8'd0, alu_in1}, 16'h005A);
        chk("wbfwd_in2", {8'd0, alu_in2}, 16'h005A);

        // Immediate wins over a matching rs2
        ex_alu_out = 8'hC3;
        wb_we      = 1'b0;
        instr(4'h5, 3'd2, 3'd6, 3'd0, 1'b1, 8'h22, 8'h99, 1'b1, 8'h7F);
        tick();
        chk("imm_in1", {8'd0, alu_in1}, 16'h0022);
        chk("imm_in2", {8'd0, alu_in2}, 16'h007F);

        // Register 0 never forwards (EX rd=0 writing, WB rd=0 writing)
        ex_alu_out = 8'hE1;
        wb_we      = 1'b1;
        wb_rd      = 3'd0;
        wb_data    = 8'hD2;
        instr(4'h3, 3'd0, 3'd0, 3'd7, 1'b1, 8'h3C, 8'h4B, 1'b0, 8'h00);
        tick();
        chk("r0_in1", {8'd0, alu_in1}, 16'h003C);
        chk("r0_in2", {8'd0, alu_in2}, 16'h004B);

        // Stall for 3 cycles while decode changes
        stall      = 1'b1;
        ex_alu_out = 8'h10;
        wb_we      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            instr(4'(9 + i), 3'd7, 3'd7, 3'(i), 1'b0, 8'hFF, 8'hEE, 1'b0, 8'h00);
            tick();
            chk("stall_in1", {8'd0, alu_in1}, 16'h003C);
            chk("stall_op",  {12'd0, alu_op}, 16'h0003);
        end
        chk("stall_in2",   {8'd0, alu_in2},   16'h004B);
        chk("stall_rd",    {13'd0, ex_rd},    16'd7);
        chk("stall_valid", {15'd0, ex_valid}, 16'd1);

        // Release stall: dependent instruction forwards from EX
        stall = 1'b0;
        instr(4'h4, 3'd7, 3'd1, 3'd2, 1'b1, 8'h00, 8'h20, 1'b0, 8'h00);
        tick();
        chk("unstall_in1", {8'd0, alu_in1}, 16'h0010);
        chk("unstall_in2", {8'd0, alu_in2}, 16'h0020);
        chk("unstall_op",  {12'd0, alu_op}, 16'h0004);

        // Flush and stall together: flush wins
        stall = 1'b1;
        flush = 1'b1;
        instr(4'h6, 3'd1, 3'd1, 3'd5, 1'b1, 8'h77, 8'h88, 1'b0, 8'h00);
        tick();
        chk_bubble("flush");

        // After bubble, EX rd=0/invalid: no EX forwarding
        stall      = 1'b0;
        flush      = 1'b0;
        ex_alu_out = 8'hAA;
        instr(4'h5, 3'd2, 3'd3, 3'd4, 1'b1, 8'h31, 8'h32, 1'b0, 8'h00);
        tick();
        chk("postflush_in1",   {8'd0, alu_in1},   16'h0031);
        chk("postflush_in2",   {8'd0, alu_in2},   16'h0032);
        chk("postflush_op",    {12'd0, alu_op},   16'h0005);
        chk("postflush_valid", {15'd0, ex_valid}, 16'd1);

        // Reset in the middle of a stall discards the held instruction
        stall = 1'b1;
        tick();
        chk("prerst_in1", {8'd0, alu_in1}, 16'h0031);
        rst = 1'b1;
        tick();
        chk_bubble("rststall");
        rst   = 1'b0;
        stall = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/idex_forward_reg.md
Name: idex_forward_reg

Overview:
- ID/EX pipeline register of the 8-bit pipelined datapath; sits directly upstream of the EX-stage ALU and drives its operand and opcode inputs.
- Captures the decoded instruction each cycle and resolves RAW hazards by forwarding from the instruction currently in EX (its ALU result) and from write-back.
- Supports stall (hold) and flush (bubble insertion) from the hazard/branch logic.

Parameters:
- DW, 8, datapath/operand width
- AW, 3, register index width (8 registers)
- BUBBLE_OP, 4'hF, opcode loaded on bubble; must not map to any ALU operation, so the ALU passes In1 (0) through
- ZERO_REG, 1, when 1, register index 0 is never a forwarding target or source; its read data passes through unmodified

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  decode stage holds a real instruction
- id_op  in  4  ALU opcode
- id_rs1  in  AW  source register 1 index
- id_rs2  in  AW  source register 2 index
- id_rd  in  AW  destination register index
- id_we  in  1  instruction writes id_rd
- id_rd1  in  DW  register-file read data for rs1
- id_rd2  in  DW  register-file read data for rs2
- id_use_imm  in  1  operand 2 taken from id_imm
- id_imm  in  DW  immediate
- ex_alu_out  in  DW  ALU result of the instruction currently held in this register
- wb_we  in  1  write-back stage writing this cycle
- wb_rd  in  AW  write-back destination
- wb_data  in  DW  write-back data
- stall  in  1  hold all state
- flush  in  1  load bubble
- alu_in1  out  DW  ALU operand 1
- alu_in2  out  DW  ALU operand 2
- alu_op  out  4  ALU opcode
- ex_rd  out  AW  destination of the EX instruction
- ex_we  out  1  EX instruction writes (already qualified by ex_valid)
- ex_valid  out  1  EX holds a real instruction

Behaviour:
- All state updates on rising clk only; all outputs are registers; no combinational path from inputs to outputs.
- Update priority per edge: rst > flush > stall > load.
- Bubble state (rst or flush): ex_valid=0, ex_we=0, ex_rd=0, alu_op=BUBBLE_OP, alu_in1=0, alu_in2=0.
- Stall (rst=0, flush=0, stall=1): every register holds its value. ex_alu_out is assumed stable during a stall, since the ALU is combinational on held inputs.
- Load (rst=0, flush=0, stall=0):
  - If id_valid=0, load bubble state.
  - Otherwise: alu_op<=id_op, ex_rd<=id_rd, ex_we<=id_we, ex_valid<=1, alu_in1<=fwd(id_rs1, id_rd1).
  - alu_in2<= id_imm if id_use_imm=1, else fwd(id_rs2, id_rd2).
- fwd(rs, rfdata), fixed priority:
  1. ex_valid & ex_we & (ex_rd==rs) -> ex_alu_out
  2. else wb_we & (wb_rd==rs) -> wb_data
  3. else rfdata
  - With ZERO_REG=1 and rs==0, result is always rfdata.
- Both operands are forwarded independently; rs1==rs2 may both be forwarded in the same cycle.
- Widths are exact (DW bits); no extension or truncation.
- Latency: one cycle from decode inputs to ALU inputs; back-to-back dependent instructions need no stall.
- Reset or flush asserted mid-stall discards the held instruction.

Test Plan:
- Reset: rst=1 for 2 cycles with random inputs -> ex_valid=0, ex_we=0, alu_op=4'hF, alu_in1=alu_in2=0; release with id_valid=0 -> still bubble.
- Plain load: id_op=ADD, id_rd1=8'h12, id_rd2=8'h34, no hazards -> next cycle alu_in1=8'h12, alu_in2=8'h34, alu_op=ADD, ex_valid=1.
- EX forward with priority: EX holds rd=3, we=1, ex_alu_out=8'hA5; wb_we=1, wb_rd=3, wb_data=8'h5A; next instruction rs1=3, id_rd1=8'h00 -> alu_in1=8'hA5. Repeat with ex_we=0 -> alu_in1=8'h5A.
- Immediate and r0: id_use_imm=1, id_imm=8'h7F, rs2 matches EX rd -> alu_in2=8'h7F. rs1=0 with EX rd=0, we=1 -> alu_in1=id_rd1.
- Stall: load instruction, then stall=1 for 3 cycles while decode inputs change -> all outputs unchanged; drop stall -> new instruction loaded.
- Flush vs stall: stall=1 and flush=1 on the same edge -> bubble state; next cycle a new valid instruction loads normally.
